// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed UTMI transmit path.
package usb_pkg;

  typedef enum logic [1:0] {
    OPM_NORMAL = 2'd0,
    OPM_NONDRV = 2'd1,
    OPM_RAW    = 2'd2
  } utmi_op_mode_t;

  typedef logic [7:0] bus8_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_EOP  = 2'd3
  } tx_state_t;

  localparam bus8_t      SYNC_BYTE = 8'h80;
  localparam logic [2:0] STUFF_THR = 3'd6;

endpackage

// File: rtl/usb_tx_nrzi.sv
// Bit stuffer plus NRZI encoder; line_j is the level for the bit time in progress.
module usb_tx_nrzi
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bit_tick,
  input  logic bit_in,
  input  logic raw,
  output logic line_j,
  output logic stall,
  output logic stuff_next
);

  logic       prev_j_q;
  logic [2:0] ones_q;

  // A pending stuff bit owns the current bit time; the data bit waits behind it.
  always_comb begin
    stall      = !raw && (ones_q == STUFF_THR);
    stuff_next = !raw && !stall && bit_in && (ones_q == STUFF_THR - 3'd1);
    if (raw)
      line_j = bit_in;
    else if (stall || !bit_in)
      line_j = ~prev_j_q;
    else
      line_j = prev_j_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_j_q <= 1'b1;
      ones_q   <= 3'd0;
    end else if (clr) begin
      prev_j_q <= 1'b1;
      ones_q   <= 3'd0;
    end else if (bit_tick) begin
      prev_j_q <= line_j;
      if (stall || !bit_in)
        ones_q <= 3'd0;
      else if (ones_q < STUFF_THR)
        ones_q <= ones_q + 3'd1;
    end
  end

endmodule

// File: rtl/usb_utmi_tx.sv
// UTMI full-speed transmitter: SYNC, stuffed/NRZI data bytes, then SE0-SE0-J EOP.
//
// state   | meaning
// IDLE    | line J, not driving; waits for tx_valid
// SYNC    | sending 8'h80 through the encoder
// DATA    | sending the byte captured on the last tx_ready
// EOP     | two bit times SE0, one bit time J
module usb_utmi_tx
  import usb_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          suspend_m,
  input  utmi_op_mode_t op_mode,
  input  bus8_t         data_in,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          tx_dp,
  output logic          tx_dm,
  output logic          tx_oe
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);

  tx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  bus8_t       sr_q, sr_d;
  logic        tail_q, tail_d;
  logic        raw_q, raw_d;

  logic bit_tick, byte_end, start;
  logic line_j, stall, stuff_next;

  usb_tx_nrzi u_nrzi (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state_q == ST_IDLE),
    .bit_tick   (bit_tick),
    .bit_in     (sr_q[bit_idx_q]),
    .raw        (raw_q && (state_q == ST_DATA)),
    .line_j     (line_j),
    .stall      (stall),
    .stuff_next (stuff_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_MAX;
      bit_idx_q <= 3'd0;
      sr_q      <= SYNC_BYTE;
      tail_q    <= 1'b0;
      raw_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
      tail_q    <= tail_d;
      raw_q     <= raw_d;
    end
  end

  // tail_q marks that bit 7 went out and only its trailing stuff bit remains.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    tail_d    = tail_q;
    raw_d     = raw_q;
    tx_ready  = 1'b0;

    bit_tick = (state_q != ST_IDLE) && (cnt_q == '0);
    byte_end = bit_tick && ((tail_q && stall) ||
                            (!stall && (bit_idx_q == 3'd7) && !stuff_next));
    start    = tx_valid && suspend_m && (op_mode != OPM_NONDRV);

    if (state_q != ST_IDLE)
      cnt_d = bit_tick ? CNT_MAX : cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = CNT_MAX;
        bit_idx_d = 3'd0;
        sr_d      = SYNC_BYTE;
        tail_d    = 1'b0;
        if (start) begin
          state_d = ST_SYNC;
          raw_d   = (op_mode == OPM_RAW);
        end
      end
      ST_SYNC, ST_DATA: begin
        if (byte_end) begin
          bit_idx_d = 3'd0;
          tail_d    = 1'b0;
          if (tx_valid) begin
            tx_ready = 1'b1;
            sr_d     = data_in;
            state_d  = ST_DATA;
          end else begin
            state_d  = ST_EOP;
          end
        end else if (bit_tick && !stall) begin
          if (bit_idx_q == 3'd7)
            tail_d = 1'b1;
          else
            bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_EOP: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'd2)
            state_d = ST_IDLE;
          else
            bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_oe = (state_q != ST_IDLE);
    tx_dp = 1'b1;
    tx_dm = 1'b0;
    case (state_q)
      ST_SYNC, ST_DATA: begin
        tx_dp = line_j;
        tx_dm = ~line_j;
      end
      ST_EOP: begin
        if (bit_idx_q < 3'd2) begin
          tx_dp = 1'b0;
          tx_dm = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_utmi_tx.sv
// Randomized self-checking bench for usb_utmi_tx against a per-clock line reference model.
module tb_usb_utmi_tx;
  import usb_pkg::*;

  localparam int CPB = 4;
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          suspend_m;
  utmi_op_mode_t op_mode;
  bus8_t         data_in;
  logic          tx_valid;
  logic          tx_ready, tx_dp, tx_dm, tx_oe;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] pkt_q[$];
  logic [3:0] exp_q[$];
  logic [1:0] unit_q[$];

  usb_utmi_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .suspend_m (suspend_m),
    .op_mode   (op_mode),
    .data_in   (data_in),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_dp     (tx_dp),
    .tx_dm     (tx_dm),
    .tx_oe     (tx_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, expv);
  endtask

  // Expected {oe,dp,dm,ready} for every clock from the first SYNC clock to the first IDLE clock.
  function automatic void build_exp(input bit raw);
    logic       lj;
    int         ones;
    logic [7:0] v;
    exp_q.delete();
    lj   = 1'b1;
    ones = 0;
    for (int u = 0; u <= pkt_q.size(); u++) begin
      unit_q.delete();
      v = (u == 0) ? 8'h80 : pkt_q[u-1];
      for (int b = 0; b < 8; b++) begin
        if (raw && u > 0) begin
          unit_q.push_back(v[b] ? LJ : LK);
        end else begin
          if (!v[b]) begin lj = ~lj; ones = 0; end
          else ones++;
          unit_q.push_back(lj ? LJ : LK);
          if (ones == 6) begin
            lj = ~lj;
            ones = 0;
            unit_q.push_back(lj ? LJ : LK);
          end
        end
      end
      for (int s = 0; s < unit_q.size(); s++)
        for (int c = 0; c < CPB; c++)
          exp_q.push_back({1'b1, unit_q[s],
                           (s == unit_q.size() - 1) && (c == CPB - 1) && (u < pkt_q.size())});
    end
    for (int c = 0; c < 2 * CPB; c++) exp_q.push_back(4'b1000);
    for (int c = 0; c < CPB; c++)     exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0100);
  endfunction

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 5))
      0, 1:    return 8'hFF;
      2:       return 8'h3F;
      3:       return 8'hFC;
      default: return 8'($urandom);
    endcase
  endfunction

  // Called at a quiet point with the DUT idle; returns on the negedge of the first idle clock.
  task automatic run_packet(input int pid, input bit raw, input bit chg);
    int         k, first_idle, last;
    logic [3:0] obs;
    build_exp(raw);
    last       = exp_q.size() - 1;
    first_idle = -1;
    k          = 0;
    op_mode    = raw ? OPM_RAW : OPM_NORMAL;
    suspend_m  = 1'b1;
    data_in    = pkt_q[0];
    tx_valid   = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      obs = {tx_oe, tx_dp, tx_dm, tx_ready};
      check_eq($sformatf("p%0d clk%0d oe_dp_dm_rdy", pid, i), 32'(obs), 32'(exp_q[i]));
      if (!tx_oe && first_idle < 0) first_idle = i;
      if (chg && i == 20) begin
        op_mode   = raw ? OPM_NORMAL : OPM_NONDRV;
        suspend_m = 1'b0;
      end
      if (tx_ready) begin
        @(posedge clk);
        #1;
        k++;
        if (k < pkt_q.size()) data_in = pkt_q[k];
        else begin
          tx_valid = 1'b0;
          data_in  = 8'($urandom);
        end
      end
    end
    for (int j = 0; j < 200 && first_idle < 0; j++) begin
      @(negedge clk);
      if (!tx_oe) first_idle = last + 1 + j;
    end
    check_eq($sformatf("p%0d oe_drop_clk", pid), 32'(first_idle), 32'(last));
    tx_valid = 1'b0;
  endtask

  initial begin
    int   n;
    logic seen;

    rst_n     = 1'b0;
    tx_valid  = 1'b0;
    data_in   = 8'h00;
    op_mode   = OPM_NORMAL;
    suspend_m = 1'b1;
    #1;
    check_eq("reset_state", 32'({tx_oe, tx_dp, tx_dm, tx_ready}), 32'(4'b0100));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    pkt_q = {8'h00};               run_packet(0, 1'b0, 1'b0);
    pkt_q = {8'hFF};               run_packet(1, 1'b0, 1'b0);
    pkt_q = {8'hFF, 8'hFF};        run_packet(2, 1'b0, 1'b0);
    pkt_q = {8'h3F, 8'hFC};        run_packet(3, 1'b0, 1'b0);
    pkt_q = {8'hFF};               run_packet(4, 1'b1, 1'b0);
    pkt_q = {8'hFF, 8'h3F, 8'h00}; run_packet(5, 1'b0, 1'b1);
    pkt_q = {8'h7E, 8'hFF};        run_packet(6, 1'b1, 1'b1);

    // Requests that must be ignored.
    op_mode  = OPM_NONDRV;
    data_in  = 8'hA5;
    tx_valid = 1'b1;
    seen     = 1'b0;
    repeat (60) begin @(negedge clk); seen |= tx_oe | tx_ready; end
    check_eq("nondriving_ignored", 32'(seen), 32'(0));
    op_mode   = OPM_NORMAL;
    suspend_m = 1'b0;
    seen      = 1'b0;
    repeat (60) begin @(negedge clk); seen |= tx_oe | tx_ready; end
    check_eq("suspend_ignored", 32'(seen), 32'(0));
    tx_valid  = 1'b0;
    suspend_m = 1'b1;
    @(negedge clk);

    // Abort mid-DATA with reset.
    data_in  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    repeat (45) @(negedge clk);
    check_eq("pre_reset_driving", 32'(tx_oe), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check_eq("reset_async", 32'({tx_oe, tx_dp, tx_dm, tx_ready}), 32'(4'b0100));
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= tx_oe | tx_ready | ~tx_dp | tx_dm; end
    check_eq("reset_hold", 32'(seen), 32'(0));
    tx_valid = 1'b0;
    rst_n    = 1'b1;
    seen     = 1'b0;
    repeat (20) begin @(negedge clk); seen |= tx_oe | tx_ready; end
    check_eq("no_eop_after_abort", 32'(seen), 32'(0));
    pkt_q = {8'hA5, 8'hFF}; run_packet(7, 1'b0, 1'b0);

    for (int p = 0; p < 25; p++) begin
      n = $urandom_range(1, 4);
      pkt_q.delete();
      for (int b = 0; b < n; b++) pkt_q.push_back(rnd_byte());
      run_packet(100 + p, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
